// File: rtl/booth_accumulator.sv
// booth_accumulator: accumulates NUM_TERMS signed 16-bit products per frame with a valid/ready handoff.
// Define BOOTH_ACC_SATURATE_EN to clamp overflowing adds instead of wrapping.
module booth_accumulator #(
  parameter int ACC_W = 24,
  parameter int NUM_TERMS = 4,
  localparam int CW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [15:0]      prod,
  input  logic             prod_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             overflow,
  output logic [CW-1:0]    term_cnt
);
  typedef enum logic {ACCUM, DONE} state_t;
  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_next;
  logic             w_ovf;
  logic             w_last;
  always_comb begin
    w_ext  = {{(ACC_W-16){prod[15]}}, prod};
    w_sum  = r_acc + w_ext;
    w_ovf  = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    w_last = r_cnt == CW'(NUM_TERMS - 1);
`ifdef BOOTH_ACC_SATURATE_EN
    // overflow can only happen with same-sign operands, so acc's sign picks the rail
    w_next = w_ovf ? {r_acc[ACC_W-1], {(ACC_W-1){~r_acc[ACC_W-1]}}} : w_sum;
`else
    w_next = w_sum;
`endif
  end
  always_ff @(posedge CLK) begin
    if (!RST || clear) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == DONE) begin
      if (acc_ready) begin
        r_state <= ACCUM;
        r_acc   <= '0;
        r_ovf   <= 1'b0;
      end
    end else if (prod_valid) begin
      r_acc   <= w_next;
      r_ovf   <= r_ovf | w_ovf;
      r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      r_state <= w_last ? DONE : ACCUM;
    end
  end
  assign in_ready  = r_state == ACCUM;
  assign acc_valid = r_state == DONE;
  assign acc_out   = r_acc;
  assign overflow  = r_ovf;
  assign term_cnt  = r_cnt;
endmodule

// File: tb/tb_booth_accumulator.sv
// tb_booth_accumulator: directed vectors for booth_accumulator at ACC_W=24 and ACC_W=17.
module tb_booth_accumulator;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] prod = '0;
  logic        prod_valid = 1'b0;
  logic        clear = 1'b0;
  logic        acc_ready = 1'b0;
  logic        a_in_ready, a_acc_valid, a_overflow;
  logic [23:0] a_acc_out;
  logic [1:0]  a_term_cnt;
  logic        b_in_ready, b_acc_valid, b_overflow;
  logic [16:0] b_acc_out;
  logic [1:0]  b_term_cnt;
  int n_checks = 0;
  int n_errors = 0;
`ifdef BOOTH_ACC_SATURATE_EN
  localparam logic [31:0] OVF_EXP = 32'h0FFFF;
`else
  localparam logic [31:0] OVF_EXP = 32'h10000;
`endif
  always #5 CLK = ~CLK;
  booth_accumulator u_a (
    .CLK(CLK), .RST(RST), .prod(prod), .prod_valid(prod_valid), .in_ready(a_in_ready),
    .clear(clear), .acc_out(a_acc_out), .acc_valid(a_acc_valid), .acc_ready(acc_ready),
    .overflow(a_overflow), .term_cnt(a_term_cnt)
  );
  booth_accumulator #(.ACC_W(17)) u_b (
    .CLK(CLK), .RST(RST), .prod(prod), .prod_valid(prod_valid), .in_ready(b_in_ready),
    .clear(clear), .acc_out(b_acc_out), .acc_valid(b_acc_valid), .acc_ready(acc_ready),
    .overflow(b_overflow), .term_cnt(b_term_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic push(input logic [15:0] p);
    prod_valid = 1'b1;
    prod = p;
    step();
  endtask
  task automatic idle_state(input string tag);
    check({tag, "_acc"}, 32'(a_acc_out), 32'h0);
    check({tag, "_valid"}, 32'(a_acc_valid), 32'h0);
    check({tag, "_ready"}, 32'(a_in_ready), 32'h1);
    check({tag, "_ovf"}, 32'(a_overflow), 32'h0);
    check({tag, "_cnt"}, 32'(a_term_cnt), 32'h0);
  endtask
  initial begin
    step();
    step();
    idle_state("reset");
    RST = 1'b1;
    step();
    idle_state("post_reset");
    // both widths see 4 x 0x4000: fits in 24 bits, overflows 17 bits on the 4th add
    acc_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(16'h4000);
    check("b_partial_acc", 32'(b_acc_out), 32'h0C000);
    check("b_partial_ovf", 32'(b_overflow), 32'h0);
    push(16'h4000);
    prod_valid = 1'b0;
    check("b_ovf_flag", 32'(b_overflow), 32'h1);
    check("b_ovf_acc", 32'(b_acc_out), OVF_EXP);
    check("b_ovf_valid", 32'(b_acc_valid), 32'h1);
    check("a_wide_acc", 32'(a_acc_out), 32'h010000);
    check("a_wide_ovf", 32'(a_overflow), 32'h0);
    step();
    check("b_handoff_ovf", 32'(b_overflow), 32'h0);
    idle_state("handoff1");
    // nominal frame
    push(16'hEE56);
    check("nom_cnt1", 32'(a_term_cnt), 32'h1);
    check("nom_acc1", 32'(a_acc_out), 32'hFFEE56);
    push(16'h0736);
    push(16'h0CD6);
    check("nom_cnt3", 32'(a_term_cnt), 32'h3);
    push(16'h1E06);
    prod_valid = 1'b0;
    check("nom_acc", 32'(a_acc_out), 32'h002068);
    check("nom_valid", 32'(a_acc_valid), 32'h1);
    check("nom_ready", 32'(a_in_ready), 32'h0);
    check("nom_ovf", 32'(a_overflow), 32'h0);
    check("nom_cnt_wrap", 32'(a_term_cnt), 32'h0);
    step();
    idle_state("nom_done");
    // backpressure with products pending
    acc_ready = 1'b0;
    push(16'hEE56);
    push(16'h0736);
    push(16'h0CD6);
    push(16'h1E06);
    prod = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ready", 32'(a_in_ready), 32'h0);
      check("bp_acc", 32'(a_acc_out), 32'h002068);
      check("bp_valid", 32'(a_acc_valid), 32'h1);
      check("bp_cnt", 32'(a_term_cnt), 32'h0);
    end
    acc_ready = 1'b1;
    step();
    idle_state("bp_release");
    prod_valid = 1'b0;
    step();
    idle_state("bp_no_accept");
    // clear with a simultaneous product, then clear from DONE
    push(16'h0010);
    push(16'h0020);
    check("clr_pre_cnt", 32'(a_term_cnt), 32'h2);
    check("clr_pre_acc", 32'(a_acc_out), 32'h000030);
    clear = 1'b1;
    push(16'h0100);
    clear = 1'b0;
    idle_state("clr");
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h0001);
    prod_valid = 1'b0;
    check("clr_frame_acc", 32'(a_acc_out), 32'h000004);
    check("clr_frame_valid", 32'(a_acc_valid), 32'h1);
    clear = 1'b1;
    acc_ready = 1'b1;
    step();
    clear = 1'b0;
    idle_state("clr_done");
    // reset mid-frame, with a product presented during reset
    for (int i = 0; i < 3; i++) push(16'h0005);
    check("rst_pre_acc", 32'(a_acc_out), 32'h00000F);
    RST = 1'b0;
    push(16'h0005);
    RST = 1'b1;
    prod_valid = 1'b0;
    idle_state("rst_mid");
    for (int i = 0; i < 4; i++) push(16'h0002);
    prod_valid = 1'b0;
    check("rst_next_acc", 32'(a_acc_out), 32'h000008);
    check("rst_next_valid", 32'(a_acc_valid), 32'h1);
    step();
    // gapped input, 4 x -1
    for (int i = 0; i < 4; i++) begin
      push(16'hFFFF);
      prod_valid = 1'b0;
      if (i < 3) check("gap_valid_early", 32'(a_acc_valid), 32'h0);
      if (i < 3) step();
    end
    check("gap_acc", 32'(a_acc_out), 32'hFFFFFC);
    check("gap_valid", 32'(a_acc_valid), 32'h1);
    check("gap_ovf", 32'(a_overflow), 32'h0);
    step();
    idle_state("gap_done");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
